// File: rtl/fetch_align_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_align_buffer
// Brief    : RV32IC fetch front end; realigns 16-bit parcels into instructions.
// Revision : 1.0
// ============================================================================
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_is_compressed
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [c_PTR_W:0]   c_DEPTH_PTR = (c_PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TWO       = c_CNT_W'(2);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [15:0]          r_queue [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [31:0]          r_head_pc;
    logic [31:0]          r_fetch_addr;
    logic                 r_skip_low;
    logic                 r_discard;

    logic [c_PTR_W-1:0]   w_head_p1;
    logic [c_PTR_W-1:0]   w_tail_p1;
    logic [15:0]          w_p0;
    logic [15:0]          w_p1;
    logic                 w_is_c;
    logic                 w_valid;
    logic                 w_take;
    logic [1:0]           w_pop_n;
    logic [1:0]           w_push_n;
    logic [c_CNT_W-1:0]   w_pop_ext;
    logic [c_CNT_W-1:0]   w_push_ext;
    logic [c_CNT_W-1:0]   w_free;
    logic [c_CNT_W-1:0]   w_need;
    logic [31:0]          w_pc_inc;
    logic                 w_req;
    logic                 w_rsp;

    // Pointers wrap modulo the depth, which need not be a power of two.
    function automatic logic [c_PTR_W-1:0] ptr_add(input logic [c_PTR_W-1:0] ptr,
                                                   input logic [1:0]         n);
        logic [c_PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(c_PTR_W - 1){1'b0}}, n};
        if (sum >= c_DEPTH_PTR) begin
            sum = sum - c_DEPTH_PTR;
        end
        return sum[c_PTR_W-1:0];
    endfunction

    assign w_head_p1 = ptr_add(r_head, 2'd1);
    assign w_tail_p1 = ptr_add(r_tail, 2'd1);
    assign w_p0      = r_queue[r_head];
    assign w_p1      = r_queue[w_head_p1];
    assign w_is_c    = (w_p0[1:0] != 2'b11);
    assign w_valid   = (r_count >= c_ONE) && (w_is_c || (r_count >= c_TWO));

    always_comb begin
        instr_valid         = w_valid;
        instr_data          = 32'd0;
        instr_pc            = 32'd0;
        instr_is_compressed = 1'b0;
        if (w_valid) begin
            instr_pc            = r_head_pc;
            instr_is_compressed = w_is_c;
            instr_data          = w_is_c ? {16'd0, w_p0} : {w_p1, w_p0};
        end
    end

    assign w_take     = w_valid && instr_ready && !redirect_valid;
    assign w_pop_n    = w_take ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;
    assign w_pc_inc   = w_take ? (w_is_c ? 32'd2 : 32'd4) : 32'd0;
    assign w_rsp      = (r_state == ST_WAIT) && imem_rsp_valid && !r_discard && !redirect_valid;
    assign w_push_n   = w_rsp ? (r_skip_low ? 2'd1 : 2'd2) : 2'd0;
    assign w_pop_ext  = {{(c_CNT_W - 2){1'b0}}, w_pop_n};
    assign w_push_ext = {{(c_CNT_W - 2){1'b0}}, w_push_n};

    // Parcels leaving this cycle already count as free space for the next word.
    assign w_free = c_DEPTH_CNT - r_count + w_pop_ext;
    assign w_need = r_skip_low ? c_ONE : c_TWO;
    assign w_req  = rst_n && (r_state == ST_REQ) && !redirect_valid && (w_free >= w_need);

    assign imem_req_valid = w_req;
    assign imem_req_addr  = r_fetch_addr;

    always_ff @(posedge clk) begin
        if (w_rsp) begin
            if (r_skip_low) begin
                r_queue[r_tail] <= imem_rsp_data[31:16];
            end else begin
                r_queue[r_tail]    <= imem_rsp_data[15:0];
                r_queue[w_tail_p1] <= imem_rsp_data[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_REQ;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_head_pc    <= RESET_PC & ~32'd1;
            r_fetch_addr <= RESET_PC & ~32'd3;
            r_skip_low   <= RESET_PC[1];
            r_discard    <= 1'b0;
        end else if (redirect_valid) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_head_pc    <= redirect_pc & ~32'd1;
            r_fetch_addr <= redirect_pc & ~32'd3;
            r_skip_low   <= redirect_pc[1];
            // A response landing in this very cycle is simply dropped; otherwise
            // the stale one still in flight must be swallowed later.
            if (r_state == ST_WAIT) begin
                if (imem_rsp_valid) begin
                    r_state   <= ST_REQ;
                    r_discard <= 1'b0;
                end else begin
                    r_discard <= 1'b1;
                end
            end
        end else begin
            r_head    <= ptr_add(r_head, w_pop_n);
            r_head_pc <= r_head_pc + w_pc_inc;
            r_count   <= r_count - w_pop_ext + w_push_ext;
            case (r_state)
                ST_REQ: begin
                    if (w_req && imem_req_ready) begin
                        r_state      <= ST_WAIT;
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state   <= ST_REQ;
                        r_discard <= 1'b0;
                        if (!r_discard) begin
                            r_skip_low <= 1'b0;
                            r_tail     <= ptr_add(r_tail, w_push_n);
                        end
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_align_buffer
// Brief    : Directed scoreboard bench for fetch_align_buffer.
// Revision : 1.0
// ============================================================================
module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_is_compressed;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        c;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] mem [0:15];
    int          cyc       = 0;
    int          total     = 0;
    int          bad       = 0;
    int          rsp_delay = 0;
    bit          slow4     = 1'b0;

    fetch_align_buffer #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .imem_req_valid      (imem_req_valid),
        .imem_req_addr       (imem_req_addr),
        .imem_req_ready      (imem_req_ready),
        .imem_rsp_valid      (imem_rsp_valid),
        .imem_rsp_data       (imem_rsp_data),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_data          (instr_data),
        .instr_pc            (instr_pc),
        .instr_is_compressed (instr_is_compressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data, input logic c);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    // Memory model: log accepted requests, answer them after 1+delay cycles.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pend_t p;
            addr_log.push_back(imem_req_addr);
            p.addr = imem_req_addr;
            p.due  = cyc + 1 + ((slow4 && imem_req_addr == 32'h4) ? 6 : rsp_delay);
            pend_q.push_back(p);
        end
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem[pend_q[0].addr[5:2]];
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard monitor: every decode handshake must match the next expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid && instr_ready && !redirect_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h data %h, expected none", instr_pc, instr_data);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr_data", instr_data, e.data);
                chk("instr_is_compressed", {31'd0, instr_is_compressed}, {31'd0, e.c});
            end
        end
    end

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        while (pend_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        exp_q.delete();
        addr_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d instrs still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    task automatic wait_addr_count(input int want, input string name);
        int n;
        n = 0;
        while (addr_log.size() < want && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, (addr_log.size() >= want) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [31:0] snap_data;

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        fill_mem(32'h0000_0013);

        // Reset state and first-fetch latency
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_c", {31'd0, instr_is_compressed}, 32'd0);
        mem[1] = 32'h0010_0093;
        do_reset();
        @(negedge clk);
        chk("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("c0_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("c1_instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("c2_instr_valid", {31'd0, instr_valid}, 32'd1);
        @(posedge clk);
        #1;
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h4, 32'h0010_0093, 1'b0);
        instr_ready = 1'b1;
        wait_drain("t1_drain");
        wait_addr_count(3, "t1_addr_count");
        if (addr_log.size() >= 3) begin
            chk("t1_addr0", addr_log[0], 32'h0);
            chk("t1_addr1", addr_log[1], 32'h4);
            chk("t1_addr2", addr_log[2], 32'h8);
        end

        // Two compressed instructions in one word
        fill_mem(32'h0000_0013);
        mem[0] = 32'h0001_4501;
        do_reset();
        expect_instr(32'h0, 32'h0000_4501, 1'b1);
        expect_instr(32'h2, 32'h0000_0001, 1'b1);
        instr_ready = 1'b1;
        wait_drain("t2_drain");

        // 32-bit instruction straddling a word boundary, slow memory
        fill_mem(32'h0000_0013);
        mem[0]    = 32'h0013_4505;
        mem[1]    = 32'h4501_0000;
        rsp_delay = 3;
        do_reset();
        expect_instr(32'h0, 32'h0000_4505, 1'b1);
        expect_instr(32'h2, 32'h0000_0013, 1'b0);
        expect_instr(32'h6, 32'h0000_4501, 1'b1);
        instr_ready = 1'b1;
        wait_drain("t3_drain");

        // Redirect to 0x6 while the fetch of 0x8 is outstanding
        fill_mem(32'h0000_0013);
        mem[1]    = 32'h4501_0000;
        rsp_delay = 5;
        do_reset();
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h4, 32'h0000_0000, 1'b1);
        instr_ready = 1'b1;
        wait_addr_count(3, "t4_addr_count");
        if (addr_log.size() >= 3) chk("t4_addr2", addr_log[2], 32'h8);
        chk("t4_pre_drained", exp_q.size(), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        @(negedge clk);
        chk("t4_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        expect_instr(32'h6, 32'h0000_4501, 1'b1);
        expect_instr(32'h8, 32'h0000_0013, 1'b0);
        wait_drain("t4_drain");
        wait_addr_count(4, "t4_addr_count2");
        if (addr_log.size() >= 4) chk("t4_addr3", addr_log[3], 32'h4);
        rsp_delay = 0;

        // Backpressure: decode stalls, queue fills, outputs hold
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013 | (i << 20);
        do_reset();
        repeat (3) @(negedge clk);
        chk("t5_valid", {31'd0, instr_valid}, 32'd1);
        chk("t5_data", instr_data, 32'h0000_0013);
        chk("t5_pc", instr_pc, 32'h0);
        snap_data = instr_data;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t5_hold_data", instr_data, snap_data);
            chk("t5_hold_pc", instr_pc, 32'h0);
        end
        chk("t5_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) expect_instr(32'(4 * i), 32'h0000_0013 | (i << 20), 1'b0);
        instr_ready = 1'b1;
        wait_drain("t5_drain");

        // Asynchronous reset while a fetch is outstanding
        fill_mem(32'h0000_0013);
        mem[1] = 32'h0020_0113;
        slow4  = 1'b1;
        do_reset();
        wait_addr_count(2, "t6_addr_count");
        @(posedge clk);
        #3;
        chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("t6_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_instr_data", instr_data, 32'd0);
        chk("t6_rst_instr_pc", instr_pc, 32'd0);
        chk("t6_rst_instr_c", {31'd0, instr_is_compressed}, 32'd0);
        addr_log.delete();
        imem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            while (pend_q.size() != 0 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        slow4          = 1'b0;
        expect_instr(32'h0, 32'h0000_0013, 1'b0);
        expect_instr(32'h4, 32'h0020_0113, 1'b0);
        instr_ready = 1'b1;
        wait_drain("t6_drain");
        if (addr_log.size() >= 1) chk("t6_first_addr", addr_log[0], 32'h0);
        else chk("t6_first_addr_seen", 32'd0, 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
